// File: rtl/float_to_int_pkg.sv
// Shared types and constants for the binary32 -> int32 conversion stage.
package float_to_int_pkg;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    CONVERT = 3'd3,
    ROUND   = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  localparam int          EXP_BIAS = 127;
  localparam int          MANT_W   = 24;
  localparam logic [31:0] INT_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN  = 32'h80000000;

endpackage

// File: rtl/float_unpack.sv
// Combinational binary32 field split: sign, unbiased exponent, mantissa with hidden bit.
module float_unpack
  import float_to_int_pkg::*;
(
  input  logic [31:0]        a,
  output logic               sign,
  output logic signed [9:0]  exp_unb,
  output logic [MANT_W-1:0]  mant,
  output logic               is_nan
);

  logic [7:0]  exp_field;
  logic [22:0] frac;

  // A zero exponent field naturally yields -127; only the hidden bit needs special handling.
  always_comb begin
    sign      = a[31];
    exp_field = a[30:23];
    frac      = a[22:0];
    exp_unb   = 10'({2'b00, exp_field}) - 10'(EXP_BIAS);
    mant      = {(exp_field != 8'd0), frac};
    is_nan    = (exp_field == 8'hFF) && (frac != 23'd0);
  end

endmodule

// File: rtl/float_to_int.sv
// binary32 -> signed int32 converter with stb/ack ports; truncates toward zero and saturates.
// Define FLOAT_TO_INT_ROUND_NEAREST_EN for round-to-nearest-even through an extra ROUND state.
module float_to_int
  import float_to_int_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output state_t      state_dbg
);

  // Handshake: a word moves on a port at a rising clk edge where its stb and ack are both
  // high; input_a_ack and output_z_stb are registered decodes of the state and never overlap.

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  localparam logic signed [9:0] E_MIN = -10'sd1;
`else
  localparam logic signed [9:0] E_MIN = 10'sd0;
`endif
  localparam logic signed [9:0] E_MAX  = 10'sd30;
  localparam logic signed [9:0] E_FRAC = 10'(MANT_W - 1);

  state_t             state, state_d;
  logic [31:0]        a_q, z_q;
  logic               sign_q, nan_q;
  logic signed [9:0]  e_q;
  logic [MANT_W-1:0]  m_q;

  logic               u_sign, u_nan;
  logic signed [9:0]  u_exp;
  logic [MANT_W-1:0]  u_mant;

  logic               is_special;
  logic [4:0]         rsh;
  logic [2:0]         lsh;
  logic [31:0]        conv_mag;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  logic [2*MANT_W-1:0] shr;
  logic                guard_c, sticky_c;
  logic [31:0]         mag_q, rnd_mag;
  logic                guard_q, sticky_q;
`else
  logic [MANT_W-1:0]   shr;
`endif

  float_unpack u_unpack (
    .a       (a_q),
    .sign    (u_sign),
    .exp_unb (u_exp),
    .mant    (u_mant),
    .is_nan  (u_nan)
  );

  assign is_special   = nan_q || (e_q < E_MIN) || (e_q > E_MAX);
  assign output_z     = z_q;
  assign state_dbg    = state;

  // Barrel shift; only meaningful in CONVERT where E_MIN <= e <= 30.
  always_comb begin
    rsh = 5'(E_FRAC - e_q);
    lsh = 3'(e_q - E_FRAC);
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    shr      = {m_q, {MANT_W{1'b0}}} >> rsh;
    guard_c  = (e_q < E_FRAC) && shr[MANT_W-1];
    sticky_c = (e_q < E_FRAC) && (|shr[MANT_W-2:0]);
    if (e_q >= E_FRAC) conv_mag = 32'(m_q) << lsh;
    else               conv_mag = 32'(shr[2*MANT_W-1:MANT_W]);
`else
    shr = m_q >> rsh;
    if (e_q >= E_FRAC) conv_mag = 32'(m_q) << lsh;
    else               conv_mag = 32'(shr);
`endif
  end

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  assign rnd_mag = mag_q + 32'(guard_q & (sticky_q | mag_q[0]));
`endif

  always_comb begin
    state_d = state;
    case (state)
      GET_A:   if (input_a_stb && input_a_ack) state_d = UNPACK;
      UNPACK:  state_d = SPECIAL;
      SPECIAL: state_d = is_special ? PUT_Z : CONVERT;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      CONVERT: state_d = ROUND;
      ROUND:   state_d = PUT_Z;
`else
      CONVERT: state_d = PUT_Z;
`endif
      PUT_Z:   if (output_z_stb && output_z_ack) state_d = GET_A;
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_d;
      input_a_ack  <= (state_d == GET_A);
      output_z_stb <= (state_d == PUT_Z);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      z_q      <= '0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state)
        GET_A: if (input_a_stb && input_a_ack) a_q <= input_a;
        UNPACK: begin
          sign_q <= u_sign;
          e_q    <= u_exp;
          m_q    <= u_mant;
          nan_q  <= u_nan;
        end
        // Same priority as is_special: NaN, then underflow to zero, then saturation.
        SPECIAL: begin
          if (nan_q)              z_q <= NAN_VALUE;
          else if (e_q < E_MIN)   z_q <= '0;
          else if (e_q > E_MAX)   z_q <= sign_q ? INT_MIN : INT_MAX;
        end
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        CONVERT: begin
          mag_q    <= conv_mag;
          guard_q  <= guard_c;
          sticky_q <= sticky_c;
        end
        ROUND: begin
          if (rnd_mag[31]) z_q <= sign_q ? INT_MIN : INT_MAX;
          else             z_q <= sign_q ? -rnd_mag : rnd_mag;
        end
`else
        CONVERT: z_q <= sign_q ? -conv_mag : conv_mag;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed cases, back-pressure, reset, random stream.
module tb_float_to_int;
  import float_to_int_pkg::*;

  localparam logic [31:0] NAN_VAL = 32'h80000000;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
  localparam int          LAT_N    = 4;
  localparam int          LAT_HALF = 4;
  localparam logic [31:0] Z_1P5    = 32'h00000002;
  localparam logic [31:0] Z_M075   = 32'hFFFFFFFF;
`else
  localparam int          LAT_N    = 3;
  localparam int          LAT_HALF = 2;
  localparam logic [31:0] Z_1P5    = 32'h00000001;
  localparam logic [31:0] Z_M075   = 32'h00000000;
`endif

  localparam int N_DIR = 16;
  logic [31:0] dir_a [N_DIR] = '{
    32'h40490FDB, 32'hC0500000, 32'h00000000, 32'h80000001,
    32'h4F000000, 32'hCF000000, 32'h7F800000, 32'h7FC00000,
    32'h80000000, 32'h3FC00000, 32'h40200000, 32'hBF400000,
    32'h3F000000, 32'h4EFFFFFF, 32'hFF800000, 32'h3F800000};
  logic [31:0] dir_z [N_DIR] = '{
    32'h00000003, 32'hFFFFFFFD, 32'h00000000, 32'h00000000,
    32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, NAN_VAL,
    32'h00000000, Z_1P5,        32'h00000002, Z_M075,
    32'h00000000, 32'h7FFFFF80, 32'h80000000, 32'h00000001};
  int dir_lat [N_DIR] = '{
    LAT_N, LAT_N, 2, 2, 2, 2, 2, 2, 2, LAT_N, LAT_N, LAT_HALF, LAT_HALF, LAT_N, 2, LAT_N};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  float_to_int #(.NAN_VALUE(NAN_VAL)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Value = significand * 2^p evaluated as a real, then truncated (or rounded) and saturated.
  function automatic logic [31:0] ref_model(input logic [31:0] a);
    logic        sgn;
    int          ef, frac, p;
    real         mag, t;
    logic [31:0] r;
    sgn  = a[31];
    ef   = int'(a[30:23]);
    frac = int'(a[22:0]);
    if (ef == 255) return (frac != 0) ? NAN_VAL : (sgn ? 32'h80000000 : 32'h7FFFFFFF);
    if (ef == 0) begin
      mag = real'(frac);
      p   = -149;
    end else begin
      mag = real'(frac + 8388608);
      p   = ef - 150;
    end
    for (int i = 0; i < p; i++) mag = mag * 2.0;
    for (int i = 0; i > p; i--) mag = mag / 2.0;
    t = $floor(mag);
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    if ((mag - t) > 0.5 || ((mag - t) == 0.5 && ($floor(t / 2.0) * 2.0) != t)) t = t + 1.0;
`endif
    if (t >= 2147483648.0) return sgn ? 32'h80000000 : 32'h7FFFFFFF;
    r = 32'($rtoi(t));
    return sgn ? -r : r;
  endfunction

  function automatic logic [31:0] rand_float();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), 23'($urandom())};
  endfunction

  // ---------------- driver tasks ----------------
  // One full transaction with output_z_ack held high once a result shows up.
  task automatic convert_one(input logic [31:0] a, output logic [31:0] z,
                             output int lat, output bit to);
    int c;
    to = 1'b0; lat = 0; z = '0; c = 0;
    @(negedge clk);
    input_a = a;
    input_a_stb = 1'b1;
    while (!input_a_ack && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!input_a_ack) begin
      input_a_stb = 1'b0;
      to = 1'b1;
      return;
    end
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    while (!output_z_stb && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!output_z_stb) begin
      to = 1'b1;
      return;
    end
    @(negedge clk);
    z = output_z;
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", input_a_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", output_z_stb); end
    checks++; if (output_z !== 32'h0) begin errors++; $display("FAIL reset_z: got %h want 0", output_z); end
    checks++; if (state_dbg !== GET_A) begin errors++; $display("FAIL reset_state: got %0d want GET_A", state_dbg); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL first_edge_ack: got %b want 1", input_a_ack); end
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL first_edge_stb: got %b want 0", output_z_stb); end
  endtask

  task automatic test_directed();
    logic [31:0] z;
    int lat;
    bit to;
    for (int i = 0; i < N_DIR; i++) begin
      convert_one(dir_a[i], z, lat, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL directed_timeout: input %h got no result", dir_a[i]);
      end else begin
        checks++;
        if (z !== dir_z[i]) begin errors++; $display("FAIL directed_z: input %h got %h want %h", dir_a[i], z, dir_z[i]); end
        checks++;
        if (lat !== dir_lat[i]) begin errors++; $display("FAIL directed_latency: input %h got %0d want %0d", dir_a[i], lat, dir_lat[i]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int c;
    c = 0;
    @(negedge clk);
    input_a = 32'h42F60000;
    input_a_stb = 1'b1;
    while (!input_a_ack && c < 50) begin @(negedge clk); c++; end
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    c = 0;
    while (!output_z_stb && c < 20) begin @(posedge clk); #1; c++; end
    checks++; if (output_z_stb !== 1'b1) begin errors++; $display("FAIL bp_result: got stb %b want 1", output_z_stb); end
    // Offer a second operand while the result is stalled; it must not be taken.
    input_a = 32'h3F800000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (output_z_stb !== 1'b1) begin errors++; $display("FAIL bp_stb: cycle %0d got %b want 1", i, output_z_stb); end
      checks++; if (output_z !== 32'h0000007B) begin errors++; $display("FAIL bp_z: cycle %0d got %h want 0000007b", i, output_z); end
      checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL bp_in_ack: cycle %0d got %b want 0", i, input_a_ack); end
    end
    input_a_stb = 1'b0;
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL bp_release_stb: got %b want 0", output_z_stb); end
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL bp_release_ack: got %b want 1", input_a_ack); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int lat, c;
    bit to;
    c = 0;
    @(negedge clk);
    input_a = 32'h40490FDB;
    input_a_stb = 1'b1;
    while (!input_a_ack && c < 50) begin @(negedge clk); c++; end
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    c = 0;
    while (state_dbg !== CONVERT && c < 10) begin @(posedge clk); #1; c++; end
    checks++; if (state_dbg !== CONVERT) begin errors++; $display("FAIL rst_mid_reach: got state %0d want CONVERT", state_dbg); end
    rst = 1'b0;
    #1;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL rst_mid_stb: got %b want 0", output_z_stb); end
    checks++; if (input_a_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b want 0", input_a_ack); end
    checks++; if (output_z !== 32'h0) begin errors++; $display("FAIL rst_mid_z: got %h want 0", output_z); end
    checks++; if (state_dbg !== GET_A) begin errors++; $display("FAIL rst_mid_state: got %0d want GET_A", state_dbg); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (output_z_stb !== 1'b0) begin errors++; $display("FAIL rst_mid_glitch: got stb %b want 0", output_z_stb); end
    checks++; if (input_a_ack !== 1'b1) begin errors++; $display("FAIL rst_mid_rearm: got %b want 1", input_a_ack); end
    convert_one(32'hC2F60000, z, lat, to);
    checks++;
    if (to) begin
      errors++; $display("FAIL rst_mid_timeout: no result after reset");
    end else begin
      checks++; if (z !== 32'hFFFFFF85) begin errors++; $display("FAIL rst_mid_first: got %h want ffffff85", z); end
      checks++; if (lat !== LAT_N) begin errors++; $display("FAIL rst_mid_latency: got %0d want %0d", lat, LAT_N); end
    end
  endtask

  task automatic test_stream();
    int got, overlap;
    bit drv_to;
    got = 0; overlap = 0; drv_to = 1'b0;
    exp_q.delete();
    fork
      begin : drv
        logic [31:0] a;
        int c;
        for (int i = 0; i < 100 && !drv_to; i++) begin
          a = rand_float();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          input_a = a;
          input_a_stb = 1'b1;
          c = 0;
          while (!input_a_ack && c < 200) begin @(negedge clk); c++; end
          if (!input_a_ack) begin
            drv_to = 1'b1;
            input_a_stb = 1'b0;
          end else begin
            exp_q.push_back(ref_model(a));
            @(posedge clk);
            #1 input_a_stb = 1'b0;
          end
        end
      end
      begin : mon
        logic [31:0] e;
        int c;
        c = 0;
        while (got < 100 && c < 20000) begin
          @(negedge clk);
          c++;
          output_z_ack = ($urandom_range(0, 2) != 0);
          if (input_a_ack && output_z_stb) overlap++;
          if (output_z_stb && output_z_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL stream_extra: unexpected result %h", output_z);
            end else begin
              e = exp_q.pop_front();
              if (output_z !== e) begin errors++; $display("FAIL stream_z: result %0d got %h want %h", got, output_z, e); end
            end
            got++;
          end
        end
        @(negedge clk);
        output_z_ack = 1'b0;
      end
    join
    checks++; if (drv_to) begin errors++; $display("FAIL stream_accept: operand not accepted in time"); end
    checks++; if (got !== 100) begin errors++; $display("FAIL stream_count: got %0d results want 100", got); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_left: %0d results missing, want 0", exp_q.size()); end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL stream_overlap: ack and stb high together %0d times, want 0", overlap); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid();
    test_stream();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Downstream stage for the single-precision multiplier.
- Consumes one IEEE-754 binary32 value per stb/ack transaction and converts it to a signed 32-bit two's-complement integer.
- Emits the result on an identical stb/ack port, e.g. to the file writer.
- Default rounding is truncation toward zero; out-of-range values saturate.

Parameters:
- NAN_VALUE, 32'h80000000, integer emitted for any NaN input.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- input_a  input  32  binary32 operand
- input_a_stb  input  1  upstream data valid
- input_a_ack  output  1  block ready; transfer when input_a_stb & input_a_ack at clk edge
- output_z  output  32  signed integer result
- output_z_stb  output  1  result valid
- output_z_ack  input  1  downstream accepts; transfer when output_z_stb & output_z_ack

Behaviour:
- Reset (rst=0, async): state=GET_A, input_a_ack=0, output_z_stb=0, output_z=0, internal registers cleared.
- First clk edge after rst deasserts: input_a_ack=1.
- FSM states: GET_A, UNPACK, SPECIAL, CONVERT, (ROUND), PUT_Z.
- GET_A: input_a_ack=1. On transfer, latch input_a, drop ack the next cycle, go to UNPACK. Only one operand is accepted per result.
- UNPACK:
  - sign=a[31]; e=a[30:23]-127 (signed 10-bit); m={1,a[22:0]}.
  - A zero exponent field gives e=-127 and hidden bit 0.
- SPECIAL, priority order:
  - exp field=255 with frac!=0: z=NAN_VALUE, go to PUT_Z.
  - e<0, including zero and denormals: z=0, go to PUT_Z.
  - e>30: z=sign?32'h80000000:32'h7FFFFFFF, go to PUT_Z. This covers inf and exactly -2^31.
  - Otherwise go to CONVERT.
- CONVERT (0<=e<=30): single-cycle barrel shift.
  - mag = e>=23 ? m<<(e-23) : m>>(23-e).
  - z = sign ? -mag : mag.
  - Go to PUT_Z (or ROUND when the optional feature is enabled).
- PUT_Z: output_z_stb=1 and output_z stable until transfer. On transfer: output_z_stb=0 next cycle, input_a_ack=1, go to GET_A.
- Latency, handshake at edge k:
  - output_z_stb=1 after edge k+3 for normal values (k+4 with rounding).
  - output_z_stb=1 after edge k+2 for special cases.
- Throughput: at most 1 result per 5 cycles.
- input_a_ack and output_z_stb are never high together.
- Back-pressure: output_z_ack low holds PUT_Z indefinitely; no input is accepted meanwhile.
- Reset mid-operation: any pending operand/result is discarded; no stb glitch.
- -0.0 converts to 0.

Optional Feature:
- Macro: FLOAT_TO_INT_ROUND_NEAREST_EN.
- Defined:
  - Adds a ROUND state after CONVERT.
  - Rounds to nearest, ties to even, using guard and sticky bits from the discarded shift bits (e<23).
  - Rounding is applied to the magnitude before negation.
  - A rounded magnitude of 2^31 saturates as in SPECIAL.
  - e=-1 (0.5<=|x|<1) is routed to CONVERT instead of z=0, so that it rounds.
- Undefined: truncation toward zero, no ROUND state, latency as above.

Decomposition:
- Package float_to_int_pkg:
  - state enum.
  - constants EXP_BIAS=127, MANT_W=24, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000.
- Optional sub-module: float_unpack, a combinational sign/exponent/mantissa split. It is reusable by sibling float stages.

Test Plan:
- 32'h40490FDB (3.14159) -> 32'h00000003, stb 3 edges after accept; 32'hC0500000 (-3.25) -> 32'hFFFFFFFD.
- Specials:
  - 32'h00000000 -> 0; 32'h80000001 -> 0.
  - 32'h4F000000 (2^31) -> 32'h7FFFFFFF; 32'hCF000000 -> 32'h80000000.
  - 32'h7F800000 -> 32'h7FFFFFFF; 32'h7FC00000 -> NAN_VALUE.
- Back-pressure: output_z_ack held 0 for 10 cycles -> output_z_stb stays 1, output_z unchanged, input_a_ack stays 0; ack=1 -> stb drops, input_a_ack rises next cycle.
- Streaming: 100 random floats with random stb/ack gaps -> results match a reference model, in order, none lost or duplicated.
- Reset: rst=0 asserted in CONVERT -> outputs 0 immediately; after release, the first new input converts correctly.
- With FLOAT_TO_INT_ROUND_NEAREST_EN:
  - 32'h3FC00000 (1.5) -> 2; 32'h40200000 (2.5) -> 2.
  - 32'hBF400000 (-0.75) -> 32'hFFFFFFFF; 32'h3F000000 (0.5) -> 0.
